mem_arbiter: RTL

- Shares one single-port unified memory between the fetch path (imem requester) and the load/store path (dmem requester) of the RISC-V core.
- Handles one transaction at a time.
- Requests go through a req/gnt handshake; responses come back on an rvalid pulse.
- Round-robin resolves conflicts. The memory has a fixed latency.

---
 rtl/risc_pkg.sv | 23 ++
 rtl/rr_arbiter2.sv | 21 ++
 rtl/mem_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/risc_pkg.sv
// Shared types for the RISC-V core memory subsystem.
// Covers access sizes plus the unified-memory arbiter state, owner and counter width.
package risc_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_size_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    typedef enum logic {
        ARB_OWN_IMEM = 1'b0,
        ARB_OWN_DMEM = 1'b1
    } arb_owner_t;

    localparam int ARB_LAT_W = 4;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick.
// Bit 0 is the fetch path and bit 1 is the load/store path; the grant is one-hot or zero.
module rr_arbiter2
    import risc_pkg::*;
(
    input  logic [1:0]  req_i,
    input  arb_owner_t  last_grant_i,
    output logic [1:0]  gnt_o
);

    // On a conflict the side that did not win last time takes the slot
    always_comb begin
        gnt_o = 2'b00;
        if (req_i == 2'b11) begin
            gnt_o = (last_grant_i == ARB_OWN_IMEM) ? 2'b10 : 2'b01;
        end else begin
            gnt_o = req_i;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-port fixed-latency memory between the fetch and load/store paths, one access at a time.
// Define MEM_ARB_PERF_EN to add saturating grant and stall counters.
module mem_arbiter
    import risc_pkg::*;
#(
    parameter int MEM_LATENCY = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              imem_req,
    input  logic [ADDR_W-1:0] imem_addr,
    output logic              imem_gnt,
    output logic              imem_rvalid,
    output logic [DATA_W-1:0] imem_rdata,
    input  logic              dmem_req,
    input  logic              dmem_wr_en,
    input  mem_size_t         dmem_size,
    input  logic [ADDR_W-1:0] dmem_addr,
    input  logic [DATA_W-1:0] dmem_wr_data,
    output logic              dmem_gnt,
    output logic              dmem_rvalid,
    output logic [DATA_W-1:0] dmem_rdata,
    output logic              mem_req,
    output logic              mem_wr_en,
    output mem_size_t         mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_imem_grants,
    output logic [31:0]       perf_dmem_grants,
    output logic [31:0]       perf_stall_cycles
`endif
);

    localparam logic [ARB_LAT_W-1:0] LAT_DONE = ARB_LAT_W'(MEM_LATENCY);
    localparam logic [ARB_LAT_W-1:0] LAT_ONE  = ARB_LAT_W'(1);

    arb_state_t           state_q, state_d;
    logic [ARB_LAT_W-1:0] lat_cnt_q, lat_cnt_d;
    arb_owner_t           owner_q, owner_d;
    arb_owner_t           last_grant_q, last_grant_d;
    logic                 is_store_q, is_store_d;
    logic [1:0]           pick;
    logic                 rsp_done;

    rr_arbiter2 u_rr (
        .req_i        ({dmem_req, imem_req}),
        .last_grant_i (last_grant_q),
        .gnt_o        (pick)
    );

    // A request asserted during reset must not be granted, since the state update would be lost
    always_comb begin
        state_d      = state_q;
        lat_cnt_d    = lat_cnt_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        is_store_d   = is_store_q;
        imem_gnt     = 1'b0;
        dmem_gnt     = 1'b0;
        mem_req      = 1'b0;
        mem_wr_en    = 1'b0;
        mem_size     = MEM_BYTE;
        mem_addr     = '0;
        mem_wr_data  = '0;
        rsp_done     = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (!reset && pick != 2'b00) begin
                    mem_req   = 1'b1;
                    state_d   = ARB_BUSY;
                    lat_cnt_d = LAT_ONE;
                    if (pick[1]) begin
                        dmem_gnt     = 1'b1;
                        mem_wr_en    = dmem_wr_en;
                        mem_size     = dmem_size;
                        mem_addr     = dmem_addr;
                        mem_wr_data  = dmem_wr_data;
                        owner_d      = ARB_OWN_DMEM;
                        last_grant_d = ARB_OWN_DMEM;
                        is_store_d   = dmem_wr_en;
                    end else begin
                        imem_gnt     = 1'b1;
                        mem_size     = MEM_WORD;
                        mem_addr     = imem_addr;
                        owner_d      = ARB_OWN_IMEM;
                        last_grant_d = ARB_OWN_IMEM;
                        is_store_d   = 1'b0;
                    end
                end
            end
            ARB_BUSY: begin
                if (lat_cnt_q == LAT_DONE) begin
                    rsp_done  = !reset;
                    state_d   = ARB_IDLE;
                    lat_cnt_d = '0;
                end else begin
                    lat_cnt_d = lat_cnt_q + LAT_ONE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Store acknowledges carry no data, so rdata stays zero for them
    always_comb begin
        imem_rvalid = rsp_done && (owner_q == ARB_OWN_IMEM);
        dmem_rvalid = rsp_done && (owner_q == ARB_OWN_DMEM);
        imem_rdata  = imem_rvalid ? mem_rdata : '0;
        dmem_rdata  = (dmem_rvalid && !is_store_q) ? mem_rdata : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ARB_IDLE;
            lat_cnt_q    <= '0;
            owner_q      <= ARB_OWN_IMEM;
            last_grant_q <= ARB_OWN_IMEM;
            is_store_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            lat_cnt_q    <= lat_cnt_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            is_store_q   <= is_store_d;
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_imem_q, perf_dmem_q, perf_stall_q;
    logic        stall_cycle;

    assign stall_cycle = (imem_req || dmem_req) && !(imem_gnt || dmem_gnt);

    // Counters stick at all-ones rather than wrapping
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_imem_q  <= '0;
            perf_dmem_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            if (imem_gnt && perf_imem_q != 32'hFFFF_FFFF) begin
                perf_imem_q <= perf_imem_q + 32'd1;
            end
            if (dmem_gnt && perf_dmem_q != 32'hFFFF_FFFF) begin
                perf_dmem_q <= perf_dmem_q + 32'd1;
            end
            if (stall_cycle && perf_stall_q != 32'hFFFF_FFFF) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_imem_grants  = perf_imem_q;
    assign perf_dmem_grants  = perf_dmem_q;
    assign perf_stall_cycles = perf_stall_q;
`endif

endmodule
